// File: rtl/shot_capture_control_pkg.sv
// Shared game definitions: capture FSM states, shot-position type and the
// coordinate saturation helper reused by the shot-position scaler.
package shot_capture_control_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RELEASE,
      ARMED,
      DEBOUNCE,
      CAPTURE,
      COOLDOWN
   } shot_state_t;

   localparam int COORD_W = 12;
   localparam int POS_W   = 10;
   localparam logic [COORD_W-1:0] POS_MAX = 12'd1023;

   typedef logic [POS_W-1:0] shot_pos_t;

   // Clamp a raw mouse coordinate into the 10-bit playfield range.
   function automatic shot_pos_t sat_pos(input logic [COORD_W-1:0] coord);
      if (coord > POS_MAX) begin
         return POS_MAX[POS_W-1:0];
      end
      return coord[POS_W-1:0];
   endfunction

endpackage

// File: rtl/shot_capture_control_sync.sv
// Reusable two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/shot_capture_control.sv
// Turns the mouse stream into one debounced, rate-limited shot event per
// click while the game is in its shooting phase.
module shot_capture_control
   import shot_capture_control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 65000,
   parameter int COOLDOWN_CYCLES = 32500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        shot_enable,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   output logic [9:0]  shot_xpos,
   output logic [9:0]  shot_ypos,
   output logic        shot_valid,
   output logic        shot_busy
);

   localparam int CNT_MAX = (DEBOUNCE_CYCLES > COOLDOWN_CYCLES) ? DEBOUNCE_CYCLES
                                                                : COOLDOWN_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

   logic             left_s;
   shot_state_t      state;
   logic [CNT_W-1:0] cnt;
   shot_pos_t        cand_x;
   shot_pos_t        cand_y;

   sync_2ff u_left_sync (
      .clk (clk),
      .rst (rst),
      .d   (mouse_left),
      .q   (left_s)
   );

   // shot_valid is a one-cycle strobe with no back-pressure: consumers must
   // sample shot_xpos/shot_ypos on the cycle it is high; both hold afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         cand_x     <= '0;
         cand_y     <= '0;
         shot_xpos  <= '0;
         shot_ypos  <= '0;
         shot_valid <= 1'b0;
         shot_busy  <= 1'b0;
      end else begin
         shot_valid <= 1'b0;
         if (!shot_enable) begin
            state     <= IDLE;
            cnt       <= '0;
            shot_busy <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= WAIT_RELEASE;
               end
               WAIT_RELEASE: begin
                  if (!left_s) begin
                     state <= ARMED;
                  end
               end
               ARMED: begin
                  // Position is frozen at press start, not at strobe time.
                  if (left_s) begin
                     cand_x    <= sat_pos(mouse_xpos);
                     cand_y    <= sat_pos(mouse_ypos);
                     cnt       <= '0;
                     state     <= DEBOUNCE;
                     shot_busy <= 1'b1;
                  end
               end
               DEBOUNCE: begin
                  if (!left_s) begin
                     cand_x    <= '0;
                     cand_y    <= '0;
                     cnt       <= '0;
                     state     <= ARMED;
                     shot_busy <= 1'b0;
                  end else if (cnt == DEB_LAST) begin
                     state <= CAPTURE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               CAPTURE: begin
                  shot_xpos  <= cand_x;
                  shot_ypos  <= cand_y;
                  shot_valid <= 1'b1;
                  cnt        <= '0;
                  state      <= COOLDOWN;
               end
               COOLDOWN: begin
                  if (cnt == COOL_LAST) begin
                     cnt       <= '0;
                     state     <= WAIT_RELEASE;
                     shot_busy <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state     <= IDLE;
                  cnt       <= '0;
                  shot_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shot_capture_control.sv
// Bench for shot_capture_control: directed scenarios plus random clicking,
// checked against a timestamp-based model of the click rules.
module tb_shot_capture_control;
  import shot_capture_control_pkg::*;

  localparam int DEB   = 4;
  localparam int COOL  = 10;
  localparam int EXP_W = 52;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        shot_enable = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [9:0]  shot_xpos;
  logic [9:0]  shot_ypos;
  logic        shot_valid;
  logic        shot_busy;

  always #5 clk = ~clk;

  shot_capture_control #(
    .DEBOUNCE_CYCLES (DEB),
    .COOLDOWN_CYCLES (COOL)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .shot_enable (shot_enable),
    .mouse_xpos  (mouse_xpos),
    .mouse_ypos  (mouse_ypos),
    .mouse_left  (mouse_left),
    .shot_xpos   (shot_xpos),
    .shot_ypos   (shot_ypos),
    .shot_valid  (shot_valid),
    .shot_busy   (shot_busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0;
  int last_valid_cyc = -1;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A press is a run of synchronised-high samples. It is accepted only when it
  // starts while armed; it fires DEB+1 samples after its start, after which
  // nothing counts until the cooldown has elapsed and the button is released.
  int m_blocked;
  int m_run_start;
  bit m_need_rel;
  int m_cx, m_cy;
  bit m_d1, m_d2;
  int m_last_x, m_last_y;

  function automatic int sat(input int v);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic m_reset();
    m_blocked   = cyc + 1;
    m_run_start = -1;
    m_need_rel  = 1'b1;
    m_d1        = 1'b0;
    m_d2        = 1'b0;
    m_last_x    = 0;
    m_last_y    = 0;
    exp_q.delete();
  endtask

  task automatic m_step();
    int n;
    bit ls;
    n    = cyc;
    ls   = m_d2;
    m_d2 = m_d1;
    m_d1 = mouse_left;
    if (!shot_enable) begin
      m_need_rel  = 1'b1;
      m_run_start = -1;
      m_blocked   = n + 1;
    end else if (n <= m_blocked) begin
    end else if (m_need_rel) begin
      if (!ls) m_need_rel = 1'b0;
    end else if (m_run_start < 0) begin
      if (ls) begin
        m_run_start = n;
        m_cx = sat(int'(mouse_xpos));
        m_cy = sat(int'(mouse_ypos));
      end
    end else if (n - m_run_start <= DEB) begin
      if (!ls) m_run_start = -1;
    end else begin
      exp_q.push_back({32'(n), 10'(m_cx), 10'(m_cy)});
      m_last_x    = m_cx;
      m_last_y    = m_cy;
      m_blocked   = n + COOL;
      m_need_rel  = 1'b1;
      m_run_start = -1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else begin
        cyc++;
        m_step();
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] e;
    bit expect_now;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        expect_now = (exp_q.size() > 0) && (int'(exp_q[0][51:20]) <= cyc);
        chk("valid_strobe", int'(shot_valid), int'(expect_now));
        if (expect_now) begin
          e = exp_q.pop_front();
          if (shot_valid) begin
            chk("valid_cycle", cyc, int'(e[51:20]));
            chk("valid_x", int'(shot_xpos), int'(e[19:10]));
            chk("valid_y", int'(shot_ypos), int'(e[9:0]));
            chk("busy_after_shot", int'(shot_busy), 1);
          end
        end
        if (shot_valid) begin
          n_valid++;
          last_valid_cyc = cyc;
        end
        chk("hold_x", int'(shot_xpos), m_last_x);
        chk("hold_y", int'(shot_ypos), m_last_y);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pos(input int x, input int y);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_x", int'(shot_xpos), 0);
    chk("areset_y", int'(shot_ypos), 0);
    chk("areset_valid", int'(shot_valid), 0);
    chk("areset_busy", int'(shot_busy), 0);
    tick(2);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0, press_edge;

    #12;
    chk("reset_x", int'(shot_xpos), 0);
    chk("reset_y", int'(shot_ypos), 0);
    chk("reset_valid", int'(shot_valid), 0);
    chk("reset_busy", int'(shot_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic shot
    shot_enable = 1'b1;
    set_pos(400, 300);
    tick(4);
    v0 = n_valid;
    press_edge = cyc + 1;
    mouse_left = 1'b1;
    tick(20);
    chk("basic_pulses", n_valid - v0, 1);
    chk("basic_latency", last_valid_cyc - press_edge, DEB + 3);
    chk("basic_x", int'(shot_xpos), 400);
    chk("basic_y", int'(shot_ypos), 300);
    mouse_left = 1'b0;
    tick(COOL + 6);

    // glitch then a real press
    v0 = n_valid;
    set_pos(120, 80);
    mouse_left = 1'b1;
    tick(3);
    mouse_left = 1'b0;
    tick(4);
    chk("glitch_pulses", n_valid - v0, 0);
    chk("glitch_state", int'(dut.state), int'(ARMED));
    mouse_left = 1'b1;
    tick(6);
    mouse_left = 1'b0;
    tick(4);
    chk("after_glitch_pulses", n_valid - v0, 1);
    chk("after_glitch_x", int'(shot_xpos), 120);
    tick(COOL + 6);

    // saturation, position frozen at press start
    set_pos(1500, 2000);
    mouse_left = 1'b1;
    tick(3);
    set_pos(50, 60);
    tick(9);
    mouse_left = 1'b0;
    chk("sat_x", int'(shot_xpos), 1023);
    chk("sat_y", int'(shot_ypos), 1023);
    tick(COOL + 6);

    // long hold, re-press inside cooldown, re-press after release
    v0 = n_valid;
    set_pos(10, 20);
    mouse_left = 1'b1;
    tick(40);
    mouse_left = 1'b0;
    tick(COOL + 4);
    chk("long_hold_pulses", n_valid - v0, 1);
    v0 = n_valid;
    mouse_left = 1'b1;
    tick(9);
    mouse_left = 1'b0;
    tick(2);
    mouse_left = 1'b1;
    tick(6);
    mouse_left = 1'b0;
    tick(COOL);
    chk("cooldown_repress_pulses", n_valid - v0, 1);
    set_pos(700, 5);
    mouse_left = 1'b1;
    tick(8);
    mouse_left = 1'b0;
    tick(COOL + 6);
    chk("second_shot_pulses", n_valid - v0, 2);
    chk("second_shot_x", int'(shot_xpos), 700);

    // disable during debounce
    v0 = n_valid;
    set_pos(333, 444);
    mouse_left = 1'b1;
    tick(4);
    shot_enable = 1'b0;
    tick(6);
    chk("disable_pulses", n_valid - v0, 0);
    chk("disable_state", int'(dut.state), int'(IDLE));
    chk("disable_busy", int'(shot_busy), 0);
    chk("disable_hold_x", int'(shot_xpos), 700);
    shot_enable = 1'b1;
    tick(20);
    chk("reenable_held_pulses", n_valid - v0, 0);
    mouse_left = 1'b0;
    tick(3);
    mouse_left = 1'b1;
    tick(8);
    mouse_left = 1'b0;
    chk("reenable_press_pulses", n_valid - v0, 1);
    chk("reenable_x", int'(shot_xpos), 333);
    tick(COOL + 6);

    // async reset mid-cooldown, then a clean shot
    set_pos(900, 901);
    mouse_left = 1'b1;
    tick(10);
    mouse_left = 1'b0;
    async_reset();
    tick(4);
    v0 = n_valid;
    set_pos(400, 300);
    press_edge = cyc + 1;
    mouse_left = 1'b1;
    tick(20);
    chk("post_reset_pulses", n_valid - v0, 1);
    chk("post_reset_latency", last_valid_cyc - press_edge, DEB + 3);
    chk("post_reset_x", int'(shot_xpos), 400);
    mouse_left = 1'b0;
    tick(COOL + 6);

    // random clicking
    for (int i = 0; i < 400; i++) begin
      shot_enable = ($urandom_range(0, 19) != 0);
      mouse_left  = $urandom_range(0, 1) != 0;
      set_pos($urandom_range(0, 4095), $urandom_range(0, 4095));
      if ($urandom_range(0, 49) == 0) async_reset();
      else tick($urandom_range(1, 12));
    end
    shot_enable = 1'b1;
    mouse_left = 1'b0;
    tick(COOL + 10);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
